// File: rtl/apb_requester_if.sv
// Request/response and APB4 bus signals of apb_requester, bundled for module ports.
// master: the requester block itself; slave: core-side requester plus APB peripheral.
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_strb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: single-outstanding request/response port to APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout enabled by defining APB_REQUESTER_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_requester_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef APB_REQUESTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                rsp_timeout_q, rsp_timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_REQUESTER_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    paddr_d  = bus.req_addr;
                    pwrite_d = bus.req_write;
                    pwdata_d = bus.req_wdata;
                    // APB4 requires inactive strobes on reads
                    pstrb_d  = bus.req_write ? bus.req_strb : '0;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_REQUESTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_d   = bus.PSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef APB_REQUESTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (wait_cnt_q == CNT_LIM) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_REQUESTER_TIMEOUT_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: stimulus queues expected responses, a monitor
// pops them on every rsp_valid; APB phase timing is checked inline by the stimulus.
module tb_apb_requester;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;

    rsp_t exp_q[$];

    apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_requester #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .PCLK(clk),
        .PRESETn(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every rsp_valid cycle must match the oldest queued expectation
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected_queue_size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
                chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, e.to});
            end
        end
    end

    task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int unsigned waits, input logic [31:0] prdata,
                           input logic slverr, input logic hold);
        rsp_t e;
        logic [3:0] exp_strb;
        exp_strb = wr ? strb : 4'h0;
        chk({tag, "_idle_psel"}, {31'd0, bus.PSEL}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        e.rdata = wr ? 32'd0 : prdata;
        e.err   = slverr;
        e.to    = 1'b0;
        exp_q.push_back(e);
        tick();
        if (!hold) bus.req_valid = 1'b0;
        chk({tag, "_setup_sel_en"}, {30'd0, bus.PSEL, bus.PENABLE}, 32'd2);
        chk({tag, "_setup_paddr"}, bus.PADDR, addr);
        chk({tag, "_setup_pwrite"}, {31'd0, bus.PWRITE}, {31'd0, wr});
        chk({tag, "_setup_pwdata"}, bus.PWDATA, wdata);
        chk({tag, "_setup_pstrb"}, {28'd0, bus.PSTRB}, {28'd0, exp_strb});
        chk({tag, "_setup_ready"}, {31'd0, bus.req_ready}, 32'd0);
        // Slave response presented during SETUP must be ignored
        bus.PREADY  = 1'b1;
        bus.PSLVERR = 1'b1;
        bus.PRDATA  = 32'hDEAD_BEEF;
        tick();
        for (int unsigned j = 0; j <= waits; j++) begin
            chk({tag, "_access_sel_en"}, {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
            chk({tag, "_access_paddr"}, bus.PADDR, addr);
            chk({tag, "_access_pwrite"}, {31'd0, bus.PWRITE}, {31'd0, wr});
            chk({tag, "_access_pstrb"}, {28'd0, bus.PSTRB}, {28'd0, exp_strb});
            bus.PREADY  = (j == waits);
            bus.PRDATA  = (j == waits) ? prdata : (32'hBAD0_0000 | j);
            bus.PSLVERR = (j == waits) ? slverr : 1'b1;
            tick();
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h0;
        chk({tag, "_resp_sel_en"}, {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
        chk({tag, "_resp_ready"}, {31'd0, bus.req_ready}, 32'd0);
        tick();
        chk({tag, "_post_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_post_ready"}, {31'd0, bus.req_ready}, 32'd1);
        chk({tag, "_post_paddr_hold"}, bus.PADDR, addr);
        chk({tag, "_post_rdata_hold"}, bus.rsp_rdata, e.rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rsp_t e;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.PRDATA    = '0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        tick();
        chk("reset_psel_en", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
        chk("reset_paddr", bus.PADDR, 32'd0);
        chk("reset_pwdata", bus.PWDATA, 32'd0);
        chk("reset_pwrite_pstrb", {27'd0, bus.PWRITE, bus.PSTRB}, 32'd0);
        chk("reset_rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("release_ready", {31'd0, bus.req_ready}, 32'd1);

        do_xfer("wr0", 1'b1, 32'h04, 32'h0000_01B2, 4'hF, 0, 32'h0, 1'b0, 1'b0);
        do_xfer("rd_wait3", 1'b0, 32'h10, 32'h1234_5678, 4'hA, 3, 32'h0000_0005, 1'b0, 1'b0);
        do_xfer("wr_err", 1'b1, 32'h10, 32'h0000_CAFE, 4'h3, 0, 32'h0, 1'b1, 1'b0);
        do_xfer("b2b_a", 1'b0, 32'h08, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0, 1'b1);
        do_xfer("b2b_b", 1'b0, 32'h08, 32'h0, 4'h0, 1, 32'h2222_2222, 1'b0, 1'b0);
        do_xfer("rd_wait4", 1'b0, 32'h14, 32'h0, 4'h0, 4, 32'h0000_0044, 1'b0, 1'b0);

`ifdef APB_REQUESTER_TIMEOUT_EN
        e.rdata = 32'd0;
        e.err   = 1'b1;
        e.to    = 1'b1;
        exp_q.push_back(e);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h20;
        tick();
        bus.req_valid = 1'b0;
        tick();
        n = 0;
        while (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("timeout_access_cycles", n, 5);
        chk("timeout_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        tick();
        chk("timeout_post_ready", {31'd0, bus.req_ready}, 32'd1);
`else
        do_xfer("rd_nowait_limit", 1'b0, 32'h20, 32'h0, 4'h0, 10, 32'h0000_0A0A, 1'b0, 1'b0);
`endif

        do_xfer("rd_err", 1'b0, 32'h30, 32'h0, 4'h0, 0, 32'h0000_0077, 1'b1, 1'b0);

        // Reset pulsed in the middle of an ACCESS wait
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h40;
        bus.req_wdata = 32'h5555_AAAA;
        bus.req_strb  = 4'hF;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("rst_pre_sel_en", {30'd0, bus.PSEL, bus.PENABLE}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_sel_en", {30'd0, bus.PSEL, bus.PENABLE}, 32'd0);
        chk("rst_async_err", {31'd0, bus.rsp_err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_post_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_post_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_post_paddr", bus.PADDR, 32'd0);
        tick();
        tick();

        do_xfer("wr_after_rst", 1'b1, 32'h44, 32'h0BAD_F00D, 4'h5, 2, 32'h0, 1'b0, 1'b0);

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
